// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, state type, inverse S-box and GF(2^8) helpers shared by both cipher directions
package aes_pkg;
   localparam int NR = 10;
   typedef logic [127:0] state_t;
   typedef enum logic {IDLE, RUN} fsm_t;
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction
   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction
   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction
   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction
endpackage

// File: rtl/inv_round.sv
// inv_round: one combinational AES inverse round; InvMixColumns is skipped on the final round
module inv_round
   import aes_pkg::*;
(
   input  state_t i_stm,
   input  state_t i_rk,
   input  logic   i_final,
   output state_t o_next
);
   state_t w_sb, w_ark, w_mix;
   // row r of column c comes from column (c - r) mod 4 before the right rotation
   for (genvar i = 0; i < 16; i++) begin : g_sb
      localparam int S = i % 4 + 4 * ((i / 4 - i % 4 + 4) % 4);
      assign w_sb[127-8*i -: 8] = INV_SBOX[i_stm[127-8*S -: 8]];
   end
   assign w_ark = w_sb ^ i_rk;
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_mix[127-8*(4*c+r) -: 8] = mule(w_ark[127-8*(4*c+r) -: 8])
                                          ^ mulb(w_ark[127-8*(4*c+(r+1)%4) -: 8])
                                          ^ muld(w_ark[127-8*(4*c+(r+2)%4) -: 8])
                                          ^ mul9(w_ark[127-8*(4*c+(r+3)%4) -: 8]);
      end
   end
   assign o_next = i_final ? w_ark : w_mix;
endmodule

// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128 decryptor, one round per clock, keys buffered from a forward-order key schedule
module inv_cipher
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         kStart,
   input  logic         kValid,
   input  logic [127:0] wBlock,
   input  logic         start,
   input  logic [127:0] in,
   output logic [127:0] out,
   output logic         done,
   output logic         ready,
   output logic         keyReady
);
   localparam logic [3:0] LAST = 4'(NR);
   fsm_t r_state, w_nstate;
   logic [3:0] r_kcnt, r_round;
   logic r_kready, r_done, w_go, w_kload, w_last;
   state_t r_stm, r_out, w_next;
   state_t r_rk [NR+1];
   assign w_go    = r_state == IDLE && start && r_kready;
   assign w_kload = r_state == IDLE && kValid && (kStart || r_kcnt <= LAST);
   assign w_last  = r_state == RUN && r_round == 4'd0;
   always_comb w_nstate = r_state == IDLE ? (w_go ? RUN : IDLE) : (w_last ? IDLE : RUN);
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else r_state <= w_nstate;
   // key buffer is don't-care after reset, so it carries no reset
   always_ff @(posedge clk)
      if (w_kload) r_rk[kStart ? 4'd0 : r_kcnt] <= wBlock;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_kcnt   <= 4'd0;
         r_kready <= 1'b0;
         r_round  <= 4'd0;
         r_stm    <= '0;
         r_out    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_last;
         if (r_state == IDLE && kStart) begin
            r_kcnt   <= {3'd0, kValid};
            r_kready <= 1'b0;
         end else if (w_kload) begin
            r_kcnt   <= r_kcnt + 4'd1;
            r_kready <= r_kcnt == LAST;
         end
         if (w_go) begin
            r_stm   <= in ^ r_rk[NR];
            r_round <= LAST - 4'd1;
         end else if (r_state == RUN && !w_last) begin
            r_stm   <= w_next;
            r_round <= r_round - 4'd1;
         end
         if (w_last) r_out <= w_next;
      end
   inv_round u_round (
      .i_stm  (r_stm),
      .i_rk   (r_rk[r_round]),
      .i_final(r_round == 4'd0),
      .o_next (w_next)
   );
   assign out      = r_out;
   assign done     = r_done;
   assign keyReady = r_kready;
   assign ready    = r_state == IDLE && r_kready;
endmodule
